// File: rtl/mem_access_pkg.sv
// Shared op encodings, RMW state type and op-class helpers for the MEM-stage access unit.
package mem_access_pkg;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LW   = 4'd1;
    localparam logic [3:0] OP_LH   = 4'd2;
    localparam logic [3:0] OP_LHU  = 4'd3;
    localparam logic [3:0] OP_LB   = 4'd4;
    localparam logic [3:0] OP_LBU  = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SB   = 4'd8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Combinational load lane select with sign/zero extension (little-endian lanes).
module load_extend
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        op,
    input  logic [1:0]        lane,
    input  logic [DATA_W-1:0] word,
    output logic [DATA_W-1:0] rdata
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        byte_s = word[{lane, 3'b000} +: 8];
        half_s = word[{lane[1], 4'b0000} +: 16];
        case (op)
            OP_LW:   rdata = word;
            OP_LH:   rdata = {{(DATA_W-16){half_s[15]}}, half_s};
            OP_LHU:  rdata = {{(DATA_W-16){1'b0}}, half_s};
            OP_LB:   rdata = {{(DATA_W-8){byte_s[7]}}, byte_s};
            OP_LBU:  rdata = {{(DATA_W-8){1'b0}}, byte_s};
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data memory access controller: one-cycle loads/sw, two-cycle RMW for sh/sb.
// Optional misalignment trap/suppression enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [31:0]       req_pc,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              align_err,
    output logic              dm_we,
    output logic              dm_re,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wd,
    output logic [31:0]       dm_pc,
    input  logic [DATA_W-1:0] dm_rd
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] merge_q, merge_d;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       pc_q;
    logic [ADDR_W-1:0] word_addr;
    logic [DATA_W-1:0] ext_rdata;
    logic              misalign;
    logic              req_ok;
    logic              rmw_start;

    assign word_addr = {req_addr[ADDR_W-1:2], 2'b00};

`ifdef MEM_ALIGN_CHECK_EN
    always_comb begin
        case (req_op)
            OP_LW, OP_SW:         misalign = (req_addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: misalign = req_addr[0];
            default:              misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    // req_* is only honoured in S_IDLE; in S_WRITE the held instruction retires.
    assign req_ok    = req_valid && (state_q == S_IDLE) && !misalign;
    assign rmw_start = req_ok && ((req_op == OP_SH) || (req_op == OP_SB));

    always_comb begin
        merge_d = dm_rd;
        if (req_op == OP_SB)
            merge_d[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
        else
            merge_d[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
    end

    load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .op    (req_op),
        .lane  (req_addr[1:0]),
        .word  (dm_rd),
        .rdata (ext_rdata)
    );

    // State and RMW capture registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            merge_q <= '0;
            addr_q  <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            if (rmw_start) begin
                merge_q <= merge_d;
                addr_q  <= word_addr;
                pc_q    <= req_pc;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (rmw_start) state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are forced quiet during reset so an aborted RMW never writes.
    always_comb begin
        stall     = 1'b0;
        rdata     = '0;
        align_err = 1'b0;
        dm_we     = 1'b0;
        dm_re     = 1'b0;
        dm_addr   = '0;
        dm_wd     = '0;
        dm_pc     = '0;
        if (!reset) begin
            if (state_q == S_WRITE) begin
                dm_we   = 1'b1;
                dm_wd   = merge_q;
                dm_addr = addr_q;
                dm_pc   = pc_q;
            end else begin
                align_err = req_valid && misalign;
                if (req_ok && is_load(req_op)) begin
                    dm_re   = 1'b1;
                    dm_addr = word_addr;
                    dm_pc   = req_pc;
                    rdata   = ext_rdata;
                end else if (req_ok && is_store(req_op)) begin
                    dm_addr = word_addr;
                    dm_pc   = req_pc;
                    if (req_op == OP_SW) begin
                        dm_we = 1'b1;
                        dm_wd = req_wdata;
                    end else begin
                        dm_re = 1'b1;
                        stall = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word-addressed DM model; honours MEM_ALIGN_CHECK_EN.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        stall;
    logic [31:0] rdata;
    logic        align_err;
    logic        dm_we;
    logic        dm_re;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic [31:0] dm_pc;
    logic [31:0] dm_rd;

    logic [31:0] mem [0:511];
    logic        pre_we;
    logic [31:0] pre_addr;
    logic [31:0] pre_val;

    int tests;
    int fails;
    int stall_cnt;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_pc    (req_pc),
        .stall     (stall),
        .rdata     (rdata),
        .align_err (align_err),
        .dm_we     (dm_we),
        .dm_re     (dm_re),
        .dm_addr   (dm_addr),
        .dm_wd     (dm_wd),
        .dm_pc     (dm_pc),
        .dm_rd     (dm_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dm_rd = mem[dm_addr[10:2]];

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_addr[10:2]] <= pre_val;
        else if (dm_we)
            mem[dm_addr[10:2]] <= dm_wd;
    end

    typedef struct {
        logic        valid;
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_stall;
        logic        exp_re;
        logic        exp_we;
        logic        chk_addr;
        logic [31:0] exp_daddr;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs [0:10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] wd);
        @(negedge clk);
        req_valid = v;
        req_op    = op;
        req_addr  = a;
        req_wdata = wd;
        req_pc    = 32'h0040_0000 + a;
        #1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_val  = v;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        stall_cnt = 0;
        pre_we = 1'b0;
        pre_addr = '0;
        pre_val = '0;
        reset = 1'b1;
        req_valid = 1'b0;
        req_op = OP_NONE;
        req_addr = '0;
        req_wdata = '0;
        req_pc = '0;

        vecs[0]  = '{1'b1, OP_LB,   32'h101, 32'h0, 32'hFFFF_FF88, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0};
        vecs[1]  = '{1'b1, OP_LBU,  32'h101, 32'h0, 32'h0000_0088, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0};
        vecs[2]  = '{1'b1, OP_LBU,  32'h103, 32'h0, 32'h0000_0011, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0};
        vecs[3]  = '{1'b1, OP_LW,   32'h100, 32'h0, 32'h1122_8844, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0};
        vecs[4]  = '{1'b1, OP_LH,   32'h100, 32'h0, 32'hFFFF_8844, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0};
        vecs[5]  = '{1'b1, OP_LHU,  32'h102, 32'h0, 32'h0000_1122, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0};
        vecs[6]  = '{1'b1, OP_LB,   32'h100, 32'h0, 32'h0000_0044, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0};
        vecs[7]  = '{1'b1, OP_NONE, 32'h100, 32'h0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0};
        vecs[8]  = '{1'b0, OP_LW,   32'h100, 32'h0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0};
        vecs[9]  = '{1'b1, OP_SW,   32'h400, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h400, 32'hCAFE_F00D};
        vecs[10] = '{1'b1, OP_LW,   32'h400, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, 1'b1, 32'h400, 32'h0};

        // Reset cycle with a valid load presented: every output must stay 0
        drive(1'b1, OP_LW, 32'h100, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'h0);
        check("rst_we", {31'b0, dm_we}, 32'h0);
        check("rst_re", {31'b0, dm_re}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_align", {31'b0, align_err}, 32'h0);
        check("rst_addr", dm_addr, 32'h0);
        check("rst_wd", dm_wd, 32'h0);
        check("rst_pc", dm_pc, 32'h0);
        req_valid = 1'b0;

        preload(32'h100, 32'h1122_8844);
        preload(32'h200, 32'h0);
        preload(32'h300, 32'h0);
        preload(32'h400, 32'h0);
        preload(32'h500, 32'h1234_5678);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].valid, vecs[i].op, vecs[i].addr, vecs[i].wdata);
            check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_stall", i), {31'b0, stall}, {31'b0, vecs[i].exp_stall});
            check($sformatf("v%0d_re", i), {31'b0, dm_re}, {31'b0, vecs[i].exp_re});
            check($sformatf("v%0d_we", i), {31'b0, dm_we}, {31'b0, vecs[i].exp_we});
            check($sformatf("v%0d_align", i), {31'b0, align_err}, 32'h0);
            if (vecs[i].chk_addr)
                check($sformatf("v%0d_daddr", i), dm_addr, vecs[i].exp_daddr);
            if (vecs[i].exp_we)
                check($sformatf("v%0d_wd", i), dm_wd, vecs[i].exp_wd);
        end

        // sb 0x102: read phase then write phase, then read back
        drive(1'b1, OP_SB, 32'h102, 32'h0000_00AB);
        check("sb_c0_stall", {31'b0, stall}, 32'h1);
        check("sb_c0_re", {31'b0, dm_re}, 32'h1);
        check("sb_c0_we", {31'b0, dm_we}, 32'h0);
        @(negedge clk);
        #1;
        check("sb_c1_stall", {31'b0, stall}, 32'h0);
        check("sb_c1_we", {31'b0, dm_we}, 32'h1);
        check("sb_c1_addr", dm_addr, 32'h100);
        check("sb_c1_wd", dm_wd, 32'h11AB_8844);
        check("sb_c1_pc", dm_pc, 32'h0040_0102);
        drive(1'b1, OP_LW, 32'h100, 32'h0);
        check("sb_readback", rdata, 32'h11AB_8844);

        // sh 0x202 over zero
        drive(1'b1, OP_SH, 32'h202, 32'h0000_BEEF);
        check("sh_c0_stall", {31'b0, stall}, 32'h1);
        @(negedge clk);
        #1;
        check("sh_c1_wd", dm_wd, 32'hBEEF_0000);
        drive(1'b1, OP_LW, 32'h200, 32'h0);
        check("sh_word", rdata, 32'hBEEF_0000);
        drive(1'b1, OP_LH, 32'h202, 32'h0);
        check("sh_lh", rdata, 32'hFFFF_BEEF);
        drive(1'b1, OP_LHU, 32'h202, 32'h0);
        check("sh_lhu", rdata, 32'h0000_BEEF);

        // Back-to-back sb to the same word; inputs held through each S_WRITE
        stall_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, OP_SB, (i < 2) ? 32'h300 : 32'h301, (i < 2) ? 32'h01 : 32'h02);
            if (stall) stall_cnt++;
        end
        check("b2b_stalls", stall_cnt, 32'd2);
        drive(1'b1, OP_LW, 32'h300, 32'h0);
        check("b2b_word", rdata, 32'h0000_0201);

        // Reset during S_WRITE aborts the write
        drive(1'b1, OP_SB, 32'h500, 32'h0000_00CC);
        check("abort_c0_stall", {31'b0, stall}, 32'h1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_we", {31'b0, dm_we}, 32'h0);
        check("abort_stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        req_op = OP_LW;
        req_addr = 32'h500;
        #1;
        check("abort_mem", rdata, 32'h1234_5678);
        check("abort_post_stall", {31'b0, stall}, 32'h0);
        check("abort_post_we", {31'b0, dm_we}, 32'h0);

`ifdef MEM_ALIGN_CHECK_EN
        drive(1'b1, OP_LW, 32'h102, 32'h0);
        check("mis_lw_align", {31'b0, align_err}, 32'h1);
        check("mis_lw_re", {31'b0, dm_re}, 32'h0);
        check("mis_lw_rdata", rdata, 32'h0);
        drive(1'b1, OP_SH, 32'h201, 32'h0000_1234);
        check("mis_sh_align", {31'b0, align_err}, 32'h1);
        check("mis_sh_stall", {31'b0, stall}, 32'h0);
        check("mis_sh_we", {31'b0, dm_we}, 32'h0);
        check("mis_sh_re", {31'b0, dm_re}, 32'h0);
        drive(1'b1, OP_LW, 32'h200, 32'h0);
        check("mis_sh_nowrite", rdata, 32'hBEEF_0000);
        check("mis_sh_idle_we", {31'b0, dm_we}, 32'h0);
`else
        drive(1'b1, OP_LW, 32'h102, 32'h0);
        check("unal_lw_align", {31'b0, align_err}, 32'h0);
        check("unal_lw_addr", dm_addr, 32'h100);
        check("unal_lw_rdata", rdata, 32'h11AB_8844);
`endif

        drive(1'b0, OP_NONE, 32'h0, 32'h0);
        check("idle_rdata", rdata, 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
